// File: rtl/stage2_pool_engine_if.sv
// Pixel stream interface for stage2_pool_engine.
//   i_in_valid / i_in_fmap           : input pixel, all CI channels packed, IBW bits each
//   o_ot_valid / o_ot_fmap           : pooled output pixel, same packing
//   o_frame_done                     : pulses with the last pooled pixel of a frame
// master: the side that produces input pixels and consumes pooled pixels.
// slave : the pooling engine.
interface stage2_pool_engine_if #(
  parameter int CI  = 3,
  parameter int IBW = 19
);
  logic              i_in_valid;
  logic [CI*IBW-1:0] i_in_fmap;
  logic              o_ot_valid;
  logic [CI*IBW-1:0] o_ot_fmap;
  logic              o_frame_done;

  modport master (
    output i_in_valid, i_in_fmap,
    input  o_ot_valid, o_ot_fmap, o_frame_done
  );

  modport slave (
    input  i_in_valid, i_in_fmap,
    output o_ot_valid, o_ot_fmap, o_frame_done
  );
endinterface

// File: rtl/stage2_pool_engine.sv
// stage2_pool_engine: streaming 2x2 / stride-2 pooling over a raster-ordered
// IW x IH feature map, CI channels in parallel, IBW-bit signed samples.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : stage2_pool_engine_if.slave (input pixel stream, pooled output
//              stream, frame-done pulse)
// Build option: define ST2_POOL_AVG_EN for 2x2 average pooling (floor); the
// default build does signed max pooling with no adders in the datapath.
module stage2_pool_engine #(
  parameter int CI  = 3,
  parameter int IBW = 19,
  parameter int IW  = 12,
  parameter int IH  = 12
) (
  input logic                  clk,
  input logic                  reset_n,
  stage2_pool_engine_if.slave  bus
);

  // Column counter is kept at least 2 bits so col[CW-1:1] (the line-buffer
  // index) is always a legal slice, even for IW == 2.
  localparam int CW = (IW > 2) ? $clog2(IW) : 2;
  localparam int RW = (IH > 2) ? $clog2(IH) : 1;
  localparam int LD = 2 ** (CW - 1);
`ifdef ST2_POOL_AVG_EN
  localparam int LBW = IBW + 1;
`else
  localparam int LBW = IBW;
`endif

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-2:0] lb_idx;
  logic          col_last;
  logic          row_last;
  logic          fire;
  logic          wr_lb;

  logic signed [IBW-1:0] smp   [CI];
  logic signed [IBW-1:0] pair  [CI];
  logic signed [IBW-1:0] res   [CI];
  logic signed [LBW-1:0] hpair [CI];
  logic signed [LBW-1:0] lb    [CI][LD];
`ifdef ST2_POOL_AVG_EN
  logic signed [IBW+1:0] sum4  [CI];
`endif
  logic [CI*IBW-1:0]     fmap_next;

  assign lb_idx   = col[CW-1:1];
  assign col_last = (col == CW'(IW - 1));
  assign row_last = (row == RW'(IH - 1));
  assign fire     = bus.i_in_valid & col[0] & row[0];
  assign wr_lb    = bus.i_in_valid & col[0] & ~row[0];

  always_comb begin
    fmap_next = '0;
    for (int unsigned c = 0; c < CI; c++) begin
      smp[c] = bus.i_in_fmap[c*IBW +: IBW];
`ifdef ST2_POOL_AVG_EN
      // Sized casts of signed operands sign-extend, so the pair sum and the
      // four-sample sum cannot overflow; >>> 2 then truncation gives floor(sum/4).
      hpair[c] = LBW'(pair[c]) + LBW'(smp[c]);
      sum4[c]  = (IBW+2)'(hpair[c]) + (IBW+2)'(lb[c][lb_idx]);
      res[c]   = IBW'(sum4[c] >>> 2);
`else
      hpair[c] = (pair[c] > smp[c]) ? pair[c] : smp[c];
      res[c]   = (hpair[c] > lb[c][lb_idx]) ? hpair[c] : lb[c][lb_idx];
`endif
      fmap_next[c*IBW +: IBW] = res[c];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col              <= '0;
      row              <= '0;
      bus.o_ot_valid   <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_ot_fmap    <= '0;
      for (int unsigned c = 0; c < CI; c++) begin
        pair[c] <= '0;
      end
    end else begin
      bus.o_ot_valid   <= fire;
      bus.o_frame_done <= fire & col_last & row_last;
      if (fire) begin
        bus.o_ot_fmap <= fmap_next;
      end
      if (bus.i_in_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          for (int unsigned c = 0; c < CI; c++) begin
            pair[c] <= smp[c];
          end
        end
      end
    end
  end

  // Line buffer is not reset: each entry is rewritten on the even row
  // before the odd row reads it.
  always_ff @(posedge clk) begin
    if (wr_lb) begin
      for (int unsigned c = 0; c < CI; c++) begin
        lb[c][lb_idx] <= hpair[c];
      end
    end
  end

endmodule

// File: tb/tb_stage2_pool_engine.sv
// Self-checking bench for stage2_pool_engine (CI=3, IBW=19, IW=4, IH=4).
// A frame-level model stores every received pixel by (row, col) and computes
// each pooled pixel directly from its four window samples.
module tb_stage2_pool_engine;
  localparam int CI  = 3;
  localparam int IBW = 19;
  localparam int IW  = 4;
  localparam int IH  = 4;
  localparam int W   = CI * IBW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  stage2_pool_engine_if #(.CI(CI), .IBW(IBW)) bus ();

  stage2_pool_engine #(.CI(CI), .IBW(IBW), .IW(IW), .IH(IH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int           due;
    logic [W-1:0] fm;
    logic         fd;
  } exp_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           fd_cnt   = 0;
  int           mr, mc;
  exp_t         exp_q [$];
  logic [W-1:0] cap_q [$];
  logic [W-1:0] last_fm;
  int           frm [IH][IW][CI];
  int           pix [IH][IW][CI];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ch_of(input logic [W-1:0] f, input int c);
    logic signed [IBW-1:0] v;
    v = f[c*IBW +: IBW];
    return int'(v);
  endfunction

  function automatic int pool4(input int a, input int b, input int c, input int d);
`ifdef ST2_POOL_AVG_EN
    int s, q;
    s = a + b + c + d;
    q = s / 4;
    if (s < 0 && q * 4 != s) q = q - 1;
    return q;
`else
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  // Model: record pixel at its raster position, predict output on odd/odd.
  task automatic model_in(input logic [W-1:0] f);
    exp_t e;
    int   v;
    for (int ch = 0; ch < CI; ch++) frm[mr][mc][ch] = ch_of(f, ch);
    if (mr % 2 == 1 && mc % 2 == 1) begin
      e.fm = '0;
      for (int ch = 0; ch < CI; ch++) begin
        v = pool4(frm[mr-1][mc-1][ch], frm[mr-1][mc][ch], frm[mr][mc-1][ch], frm[mr][mc][ch]);
        e.fm[ch*IBW +: IBW] = v[IBW-1:0];
      end
      e.due = cyc + 1;
      e.fd  = (mr == IH - 1) && (mc == IW - 1);
      exp_q.push_back(e);
    end
    if (mc == IW - 1) begin
      mc = 0;
      mr = (mr == IH - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      chk("reset_outputs", bus.o_ot_valid === 1'b0 && bus.o_ot_fmap === '0 && bus.o_frame_done === 1'b0,
          longint'({bus.o_ot_valid, bus.o_frame_done}), 0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("ot_valid", bus.o_ot_valid === 1'b1, longint'(bus.o_ot_valid), 1);
      chk("ot_fmap", bus.o_ot_fmap === e.fm, longint'(bus.o_ot_fmap), longint'(e.fm));
      chk("frame_done", bus.o_frame_done === e.fd, longint'(bus.o_frame_done), longint'(e.fd));
      last_fm = e.fm;
      cap_q.push_back(bus.o_ot_fmap);
      if (bus.o_frame_done === 1'b1) fd_cnt++;
    end else begin
      chk("idle_no_pulse", bus.o_ot_valid === 1'b0 && bus.o_frame_done === 1'b0,
          longint'({bus.o_ot_valid, bus.o_frame_done}), 0);
      chk("fmap_hold", bus.o_ot_fmap === last_fm, longint'(bus.o_ot_fmap), longint'(last_fm));
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_in_valid = 1'b0;
      bus.i_in_fmap  = W'({$urandom(), $urandom()});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_px(input logic [W-1:0] f);
    bus.i_in_valid = 1'b1;
    bus.i_in_fmap  = f;
    model_in(f);
    @(posedge clk);
    #1;
    bus.i_in_valid = 1'b0;
    bus.i_in_fmap  = W'({$urandom(), $urandom()});
  endtask

  // mode 0: continuous, 1: valid 1-of-3, 2: random gaps 0..3
  task automatic send_frame(input int mode, input int n_px);
    logic [W-1:0] f;
    int v, r, c;
    for (int i = 0; i < n_px; i++) begin
      r = i / IW;
      c = i % IW;
      f = '0;
      for (int ch = 0; ch < CI; ch++) begin
        v = pix[r][c][ch];
        f[ch*IBW +: IBW] = v[IBW-1:0];
      end
      send_px(f);
      if (mode == 1) idle(2);
      else if (mode == 2) idle(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    exp_q.delete();
    mr = 0;
    mc = 0;
    last_fm = '0;
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic fill_ramp(input int off);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        for (int ch = 0; ch < CI; ch++) pix[r][c][ch] = r * 4 + c + ch * 100 + off;
  endtask

  task automatic fill_window(input int a, input int b, input int c, input int d);
    for (int r = 0; r < IH; r++)
      for (int k = 0; k < IW; k++)
        for (int ch = 0; ch < CI; ch++) pix[r][k][ch] = 0;
    for (int ch = 0; ch < CI; ch++) begin
      pix[0][0][ch] = a;
      pix[0][1][ch] = b;
      pix[1][0][ch] = c;
      pix[1][1][ch] = d;
    end
  endtask

  task automatic lit(input string name, input int idx, input int ch, input int exp);
    int act;
    act = (idx < cap_q.size()) ? ch_of(cap_q[idx], ch) : -999999;
    chk(name, act == exp, act, exp);
  endtask

  task automatic start_case();
    cap_q.delete();
    fd_cnt = 0;
  endtask

  task automatic check_ramp(input string tag, input int base, input int off);
    lit({tag, "_c0_0"}, base + 0, 0, 5 + off);
    lit({tag, "_c0_1"}, base + 1, 0, 7 + off);
    lit({tag, "_c0_2"}, base + 2, 0, 13 + off);
    lit({tag, "_c0_3"}, base + 3, 0, 15 + off);
    lit({tag, "_c1_0"}, base + 0, 1, 105 + off);
    lit({tag, "_c2_3"}, base + 3, 2, 215 + off);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_fmap  = '0;
    mr = 0;
    mc = 0;
    last_fm = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Continuous ramp frame
    start_case();
    fill_ramp(0);
    send_frame(0, IW * IH);
    idle(3);
    check_ramp("ramp", 0, 0);
    chk("ramp_count", cap_q.size() == 4, cap_q.size(), 4);
    chk("ramp_fdone", fd_cnt == 1, fd_cnt, 1);

    // Negative window
    start_case();
    fill_window(-5, -3, -8, -1);
    send_frame(0, IW * IH);
    idle(3);
`ifdef ST2_POOL_AVG_EN
    lit("neg_window", 0, 0, -5);
`else
    lit("neg_window", 0, 0, -1);
`endif

    // Valid 1-of-3
    start_case();
    fill_ramp(0);
    send_frame(1, IW * IH);
    idle(3);
    check_ramp("sparse", 0, 0);
    chk("sparse_fdone", fd_cnt == 1, fd_cnt, 1);

    // Reset after 6 pixels, then a clean frame
    start_case();
    fill_ramp(0);
    send_frame(0, 6);
    do_reset(2);
    chk("reset_no_out", cap_q.size() == 0, cap_q.size(), 0);
    idle(2);
    send_frame(0, IW * IH);
    idle(3);
    check_ramp("post_reset", 0, 0);
    chk("post_reset_count", cap_q.size() == 4, cap_q.size(), 4);

    // Two frames back to back, second offset by 1000
    start_case();
    fill_ramp(0);
    send_frame(0, IW * IH);
    fill_ramp(1000);
    send_frame(0, IW * IH);
    idle(3);
    check_ramp("two_f1", 0, 0);
    check_ramp("two_f2", 4, 1000);
    chk("two_count", cap_q.size() == 8, cap_q.size(), 8);
    chk("two_fdone", fd_cnt == 2, fd_cnt, 2);

    // Extremes
    start_case();
    fill_window(262143, 262143, -262144, -262144);
    send_frame(0, IW * IH);
    idle(3);
`ifdef ST2_POOL_AVG_EN
    lit("extremes", 0, 0, -1);
`else
    lit("extremes", 0, 0, 262143);
`endif

    // Random data, random gaps
    start_case();
    for (int fr = 0; fr < 6; fr++) begin
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          for (int ch = 0; ch < CI; ch++)
            pix[r][c][ch] = int'($urandom_range(0, 524287)) - 262144;
      send_frame(2, IW * IH);
    end
    idle(3);
    chk("rand_count", cap_q.size() == 24, cap_q.size(), 24);
    chk("rand_fdone", fd_cnt == 6, fd_cnt, 6);

    chk("drain", exp_q.size() == 0, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage2_pool_engine.md
STAGE2_POOL_ENGINE -- requirements
Module: stage2_pool_engine

Interface
REQ-001 Parameter CI, default 3: channel count; every channel is processed in parallel.
REQ-002 Parameter IBW, default 19: per-channel sample width, signed two's complement.
REQ-003 Parameter IW, default 12: input feature-map width in pixels; SHALL be even and at least 2.
REQ-004 Parameter IH, default 12: input feature-map height in rows; SHALL be even and at least 2.
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 i_in_valid  input  1  qualifies i_in_fmap for one pixel.
REQ-008 i_in_fmap  input  CI*IBW  one pixel for all channels; channel c is at bits [c*IBW +: IBW].
REQ-009 o_ot_valid  output  1  one-cycle pulse qualifying o_ot_fmap.
REQ-010 o_ot_fmap  output  CI*IBW  pooled pixel for all channels, in the same packing as the input.
REQ-011 o_frame_done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-012 The input SHALL arrive in raster order (column fastest, then row), one pixel per valid cycle; gaps of any length between valid cycles SHALL be tolerated.
REQ-013 The block SHALL keep a column counter (0..IW-1) and a row counter (0..IH-1), both advanced only on i_in_valid.
- Column wraps to 0 after IW-1 and increments the row.
- Row wraps to 0 after IH-1, so the next frame starts with no other action.
REQ-014 Per channel, the block SHALL perform non-overlapping 2x2 pooling with stride 2; output dimensions are IW/2 by IH/2.
REQ-015 Even column: the sample SHALL be held in a pair register.
REQ-016 Odd column on an even row: the horizontal pair result SHALL be written into line-buffer entry col/2, which is IW/2 entries per channel.
REQ-017 Odd column on an odd row: the pair result SHALL be combined with line-buffer entry col/2 to form the output.
REQ-018 The combine operation SHALL be a signed maximum; on equal values either operand is returned.
REQ-019 Output timing:
- o_ot_valid SHALL be asserted exactly 1 cycle after the valid input at an odd row and odd column.
- o_ot_fmap is registered and SHALL hold its value until the next output.
REQ-020 o_frame_done SHALL pulse with the o_ot_valid caused by input (row IH-1, col IW-1).
REQ-021 Output pulses SHALL never be issued on even rows or even columns.
- Back-to-back outputs are impossible.
- The minimum spacing between outputs is 2 cycles.
REQ-022 The line buffer SHALL NOT be cleared between frames; every entry is overwritten on the even row before it is read.

Reset
REQ-023 While reset_n is low, the following SHALL be 0:
- o_ot_valid, o_ot_fmap and o_frame_done;
- the column and row counters;
- the pair registers.
REQ-024 Reset asserted mid-frame SHALL abandon the partial frame; the first valid after release is taken as pixel (0,0) of a new frame.
REQ-025 Line-buffer contents need not be reset.

Configuration
REQ-026 Macro ST2_POOL_AVG_EN controls the combine operation.
- Defined: the combine SHALL be a 2x2 average. The four signed samples are summed at IBW+2 bits, then arithmetic-shifted right by 2 (floor), then truncated to IBW.
- The line buffer then holds IBW+1-bit pair sums.
- Not defined: max pooling per REQ-018 only, and no adder logic is built.

Verification (CI=3, IBW=19, IW=4, IH=4 unless stated)
REQ-027 Continuous stream with channel c pixel value = row*4+col+c*100. Required outputs, in order:
- channel 0: 5, 7, 13, 15;
- channels 1 and 2: the same values plus 100 and 200;
- o_ot_valid exactly 1 cycle after inputs (1,1), (1,3), (3,1), (3,3);
- o_frame_done only on the 4th output.
REQ-028 Negative values: window {-5,-3,-8,-1} -> output -1 (max build); -5 (average build, floor of -17/4).
REQ-029 Valid toggled 1-of-3 cycles with the REQ-027 data -> identical output values; each output is 1 cycle after its triggering input.
REQ-030 Reset pulsed after 6 pixels, then a full frame -> no outputs before the reset; after it, exactly the REQ-027 sequence.
REQ-031 Two frames back-to-back with no gap; frame 2 = frame 1 + 1000 -> 8 outputs; second four are the first four + 1000; two o_frame_done pulses.
REQ-032 Extremes: window {max, max, min, min} with IBW=19 -> max build outputs 262143; average build outputs -1, with no overflow.
